// File: rtl/exec_sequencer.sv
// Execution controller for the i281 core: run/halt/single-step control, cycle counting and program loading.
// Optional breakpoint support is compiled in when EXEC_SEQ_BREAKPOINT_EN is defined.
module exec_sequencer #(
  parameter int unsigned PC_WIDTH    = 6,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run_req,
  input  logic                   step_req,
  input  logic                   halt_req,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   load_last,
  output logic                   load_ready,
  input  logic [PC_WIDTH-1:0]    current_pc,
`ifdef EXEC_SEQ_BREAKPOINT_EN
  input  logic [PC_WIDTH-1:0]    bp_addr,
  input  logic                   bp_valid,
  output logic                   bp_hit,
`endif
  output logic                   cpu_en,
  output logic                   cpu_clr,
  output logic                   code_we,
  output logic [PC_WIDTH-1:0]    code_addr,
  output logic [INSTR_WIDTH-1:0] code_wdata,
  output logic [1:0]             state_o,
  output logic [CNT_WIDTH-1:0]   cycle_count
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_LOAD = 2'd3
  } state_e;

  localparam logic [PC_WIDTH-1:0]  PC_LAST = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    load_cnt_q, load_cnt_d;
  logic [CNT_WIDTH-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic                   code_we_q, code_we_d;
  logic [PC_WIDTH-1:0]    code_addr_q, code_addr_d;
  logic [INSTR_WIDTH-1:0] code_wdata_q, code_wdata_d;
  logic                   cpu_clr_q, cpu_clr_d;
  logic                   bp_stop_c;

`ifdef EXEC_SEQ_BREAKPOINT_EN
  logic run_first_q, run_first_d;
  logic bp_hit_q, bp_hit_d;

  // Breakpoint stops RUN except in the first cycle after entry, so a resume can step off it.
  assign bp_stop_c = (state_q == ST_RUN) && bp_valid && (current_pc == bp_addr) && !run_first_q;
  assign bp_hit    = bp_hit_q;

  always_comb begin
    run_first_d = (state_d == ST_RUN) && (state_q != ST_RUN);
    bp_hit_d    = bp_hit_q;
    if (run_req || step_req || load_start) bp_hit_d = 1'b0;
    if (bp_stop_c) bp_hit_d = 1'b1;
  end
`else
  logic unused_pc_c;
  assign unused_pc_c = ^current_pc;
  assign bp_stop_c   = 1'b0;
`endif

  assign cpu_en      = ((state_q == ST_RUN) && !bp_stop_c) || (state_q == ST_STEP);
  assign load_ready  = (state_q == ST_LOAD);
  assign state_o     = state_q;
  assign cycle_count = cycle_cnt_q;
  assign code_we     = code_we_q;
  assign code_addr   = code_addr_q;
  assign code_wdata  = code_wdata_q;
  assign cpu_clr     = cpu_clr_q;

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    code_we_d    = 1'b0;
    code_addr_d  = code_addr_q;
    code_wdata_d = code_wdata_q;
    cpu_clr_d    = 1'b0;

    if (cpu_en && (cycle_cnt_q != CNT_MAX)) cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);

    case (state_q)
      ST_HALT: begin
        if (load_start) begin
          state_d     = ST_LOAD;
          load_cnt_d  = '0;
          cycle_cnt_d = '0;
        end else if (step_req) begin
          state_d = ST_STEP;
        end else if (run_req) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bp_stop_c || halt_req) state_d = ST_HALT;
      end
      ST_STEP: state_d = ST_HALT;
      ST_LOAD: begin
        if (load_valid) begin
          code_we_d    = 1'b1;
          code_addr_d  = load_cnt_q;
          code_wdata_d = load_data;
          load_cnt_d   = load_cnt_q + PC_WIDTH'(1);
          // Last word flagged, or top of code memory reached: leave without wrapping.
          if (load_last || (load_cnt_q == PC_LAST)) begin
            state_d   = ST_HALT;
            cpu_clr_d = 1'b1;
          end
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_HALT;
      load_cnt_q   <= '0;
      cycle_cnt_q  <= '0;
      code_we_q    <= 1'b0;
      code_addr_q  <= '0;
      code_wdata_q <= '0;
      cpu_clr_q    <= 1'b0;
`ifdef EXEC_SEQ_BREAKPOINT_EN
      run_first_q  <= 1'b0;
      bp_hit_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      code_we_q    <= code_we_d;
      code_addr_q  <= code_addr_d;
      code_wdata_q <= code_wdata_d;
      cpu_clr_q    <= cpu_clr_d;
`ifdef EXEC_SEQ_BREAKPOINT_EN
      run_first_q  <= run_first_d;
      bp_hit_q     <= bp_hit_d;
`endif
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: behavioural model compared every cycle, plus directed literal checks.
module tb_exec_sequencer;
  localparam int unsigned PW = 6;
  localparam int unsigned IW = 16;
  localparam int unsigned CW = 4;
  localparam int PC_LAST = (1 << PW) - 1;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0, load_start = 1'b0;
  logic          load_valid = 1'b0, load_last = 1'b0;
  logic [IW-1:0] load_data = '0;
  logic [PW-1:0] current_pc = '0;
  logic          load_ready, cpu_en, cpu_clr, code_we;
  logic [PW-1:0] code_addr;
  logic [IW-1:0] code_wdata;
  logic [1:0]    state_o;
  logic [CW-1:0] cycle_count;
`ifdef EXEC_SEQ_BREAKPOINT_EN
  logic [PW-1:0] bp_addr = '0;
  logic          bp_valid = 1'b0;
  logic          bp_hit;
`endif

  exec_sequencer #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .current_pc(current_pc),
`ifdef EXEC_SEQ_BREAKPOINT_EN
    .bp_addr(bp_addr), .bp_valid(bp_valid), .bp_hit(bp_hit),
`endif
    .cpu_en(cpu_en), .cpu_clr(cpu_clr), .code_we(code_we), .code_addr(code_addr),
    .code_wdata(code_wdata), .state_o(state_o), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0 HALT, 1 RUN, 2 STEP, 3 LOAD.
  int m_state = 0, m_cyc = 0, m_lcnt = 0, m_addr = 0, m_data = 0;
  bit m_we = 0, m_clr = 0, m_first = 0, m_bp = 0, started = 0;

  function automatic bit bp_stop_f();
`ifdef EXEC_SEQ_BREAKPOINT_EN
    return (m_state == 1) && bp_valid && (current_pc == bp_addr) && !m_first;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_en_f();
    return (m_state == 2) || ((m_state == 1) && !bp_stop_f());
  endfunction

  always @(posedge clock) begin
    bit en;
    en = exp_en_f();
    if (reset) begin
      m_state = 0; m_cyc = 0; m_lcnt = 0; m_addr = 0; m_data = 0;
      m_we = 0; m_clr = 0; m_first = 0; m_bp = 0;
      current_pc <= '0;
    end else begin
      // The core clears its PC on cpu_clr and advances on cpu_en.
      if (m_clr) current_pc <= '0;
      else if (en) current_pc <= current_pc + PW'(1);
      if (en && m_cyc < CNT_MAX) m_cyc++;
      m_we = 0; m_clr = 0;
      if (run_req || step_req || load_start) m_bp = 0;
      case (m_state)
        0: if (load_start) begin m_state = 3; m_lcnt = 0; m_cyc = 0; end
           else if (step_req) m_state = 2;
           else if (run_req) begin m_state = 1; m_first = 1; end
        1: begin
             if (bp_stop_f()) begin m_state = 0; m_bp = 1; end
             else if (halt_req) m_state = 0;
             m_first = 0;
           end
        2: m_state = 0;
        default: if (load_valid) begin
             m_we = 1; m_addr = m_lcnt; m_data = int'(load_data);
             if (load_last || m_lcnt == PC_LAST) begin m_state = 0; m_clr = 1; end
             m_lcnt++;
           end
      endcase
    end
    started = 1;
  end

  typedef struct { int addr; int data; bit clr; } wr_t;
  wr_t wlog[$];
  int  en_cnt = 0;

  // Per-cycle compare against the model, plus a write log and cpu_en tally for directed checks.
  always @(negedge clock) begin
    if (started) begin
      chk("state", 32'(state_o), m_state);
      chk("cpu_en", 32'(cpu_en), 32'(exp_en_f()));
      chk("load_ready", 32'(load_ready), 32'(m_state == 3));
      chk("code_we", 32'(code_we), 32'(m_we));
      chk("cpu_clr", 32'(cpu_clr), 32'(m_clr));
      chk("cycle_count", 32'(cycle_count), m_cyc);
      if (m_we) begin
        chk("code_addr", 32'(code_addr), m_addr);
        chk("code_wdata", 32'(code_wdata), m_data);
      end
`ifdef EXEC_SEQ_BREAKPOINT_EN
      chk("bp_hit", 32'(bp_hit), 32'(m_bp));
`endif
      if (code_we) wlog.push_back('{int'(code_addr), int'(code_wdata), cpu_clr});
      if (cpu_en) en_cnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [IW-1:0] exp64 [64];

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_state", 32'(state_o), 0);
    chk("rst_cpu_en", 32'(cpu_en), 0);
    chk("rst_code_we", 32'(code_we), 0);
    chk("rst_cycle_count", 32'(cycle_count), 0);
    chk("rst_code_addr", 32'(code_addr), 0);
    chk("rst_code_wdata", 32'(code_wdata), 0);
    chk("rst_load_ready", 32'(load_ready), 0);

    // Three-word load ending on load_last.
    wlog.delete();
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1;
    load_data = 16'h1111; tick();
    load_data = 16'h2222; tick();
    load_data = 16'h3333; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    repeat (2) tick();
    chk("ld3_count", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("ld3_a0", wlog[0].addr, 0); chk("ld3_d0", wlog[0].data, 32'h1111); chk("ld3_c0", 32'(wlog[0].clr), 0);
      chk("ld3_a1", wlog[1].addr, 1); chk("ld3_d1", wlog[1].data, 32'h2222); chk("ld3_c1", 32'(wlog[1].clr), 0);
      chk("ld3_a2", wlog[2].addr, 2); chk("ld3_d2", wlog[2].data, 32'h3333); chk("ld3_c2", 32'(wlog[2].clr), 1);
    end
    chk("ld3_state", 32'(state_o), 0);

    // Full-depth load without load_last: exits after address 63, no wrap to 0.
    wlog.delete();
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 66; i++) begin
      load_data = IW'($urandom);
      if (i < 64) exp64[i] = load_data;
      tick();
    end
    load_valid = 1'b0;
    tick();
    chk("ld64_count", wlog.size(), 64);
    if (wlog.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        chk("ld64_addr", wlog[i].addr, i);
        chk("ld64_data", wlog[i].data, 32'(exp64[i]));
      end
      chk("ld64_clr_last", 32'(wlog[63].clr), 1);
    end
    chk("ld64_state", 32'(state_o), 0);
    chk("ld64_cycles_cleared", 32'(cycle_count), 0);

    // Single step, then three consecutive step pulses giving two steps.
    en_cnt = 0;
    step_req = 1'b1; tick(); step_req = 1'b0;
    repeat (2) tick();
    chk("step1_en", en_cnt, 1);
    chk("step1_cycles", 32'(cycle_count), 1);
    en_cnt = 0;
    step_req = 1'b1; repeat (3) tick(); step_req = 1'b0;
    repeat (2) tick();
    chk("step3_en", en_cnt, 2);
    chk("step3_cycles", 32'(cycle_count), 3);

    // Run 10 cycles then halt: 11 enabled cycles.
    en_cnt = 0;
    run_req = 1'b1; tick(); run_req = 1'b0;
    repeat (10) tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    repeat (2) tick();
    chk("run_en", en_cnt, 11);
    chk("run_cycles", 32'(cycle_count), 14);

    // Counter saturation at all-ones.
    run_req = 1'b1; tick(); run_req = 1'b0;
    repeat (5) tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    tick();
    chk("sat_cycles", 32'(cycle_count), CNT_MAX);

    // load_start wins over run_req; then reset abandons the load without cpu_clr.
    load_start = 1'b1; run_req = 1'b1; tick(); load_start = 1'b0; run_req = 1'b0;
    chk("prio_state", 32'(state_o), 3);
    load_valid = 1'b1; load_data = 16'hABCD; tick(); load_valid = 1'b0;
    chk("midld_we", 32'(code_we), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midld_rst_we", 32'(code_we), 0);
    chk("midld_rst_clr", 32'(cpu_clr), 0);
    chk("midld_rst_state", 32'(state_o), 0);

`ifdef EXEC_SEQ_BREAKPOINT_EN
    begin
      int n;
      bp_addr = 6'd5; bp_valid = 1'b1;
      run_req = 1'b1; tick(); run_req = 1'b0;
      n = 0;
      while (state_o != 2'd0 && n < 20) begin tick(); n++; end
      chk("bp_timeout", 32'(n < 20), 1);
      chk("bp_pc", 32'(current_pc), 5);
      chk("bp_hit_set", 32'(bp_hit), 1);
      chk("bp_en_low", 32'(cpu_en), 0);
      run_req = 1'b1; tick(); run_req = 1'b0;
      chk("bp_resume_en", 32'(cpu_en), 1);
      chk("bp_resume_pc", 32'(current_pc), 5);
      chk("bp_hit_clr", 32'(bp_hit), 0);
      halt_req = 1'b1; tick(); halt_req = 1'b0;
      bp_valid = 1'b0;
    end
`endif

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      run_req    = ($urandom_range(15) == 0);
      step_req   = ($urandom_range(11) == 0);
      halt_req   = ($urandom_range(19) == 0);
      load_start = ($urandom_range(39) == 0);
      load_valid = $urandom_range(1) == 1;
      load_last  = ($urandom_range(7) == 0);
      load_data  = IW'($urandom);
      reset      = ($urandom_range(499) == 0);
`ifdef EXEC_SEQ_BREAKPOINT_EN
      bp_valid   = $urandom_range(1) == 1;
      bp_addr    = PW'($urandom_range(7));
`endif
      tick();
    end
    run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0; load_start = 1'b0;
    load_valid = 1'b0; load_last = 1'b0; reset = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
